// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  // Distance between consecutive sequential fetch addresses.
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = 32'd4;

  // The fetch FSM either waits to issue a request or waits on memctrl.
  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  // One queue entry: the fetched word tagged with the PC it came from.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Circular instruction queue holding {pc, instr} pairs between fetch and decode.
// Clear has priority over push/pop; en gates every state change.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_LEN = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en_in,
  input  logic         clear_in,
  input  logic         push_in,
  input  fetch_entry_t push_data_in,
  input  logic         pop_in,
  output logic         full_out,
  output logic         empty_out,
  output fetch_entry_t head_out
);

  localparam logic [ADDR_LEN:0]   DEPTH_CNT = (ADDR_LEN+1)'(DEPTH);
  localparam logic [ADDR_LEN-1:0] PTR_ONE   = ADDR_LEN'(1);
  localparam logic [ADDR_LEN:0]   CNT_ONE   = (ADDR_LEN+1)'(1);

  fetch_entry_t          mem_q [DEPTH];
  fetch_entry_t          mem_d [DEPTH];
  logic [ADDR_LEN-1:0]   head_q, head_d;
  logic [ADDR_LEN-1:0]   tail_q, tail_d;
  logic [ADDR_LEN:0]     count_q, count_d;
  logic                  pop_ok;
  logic                  push_ok;

  assign full_out  = (count_q == DEPTH_CNT);
  assign empty_out = (count_q == '0);
  assign head_out  = empty_out ? '0 : mem_q[head_q];

  // A pop needs data; a push needs room, which a simultaneous pop provides.
  assign pop_ok  = pop_in && !empty_out;
  assign push_ok = push_in && (!full_out || pop_ok);

  // Next-state pointers, occupancy and storage.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (en_in) begin
      if (clear_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push_ok) begin
          mem_d[tail_q] = push_data_in;
          tail_d        = tail_q + PTR_ONE;
        end
        if (pop_ok) begin
          head_d = head_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
      end
    end
  end

  // Queue registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-word requests to memctrl,
// queues returned words with their PCs and hands them to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    QUEUE_DEPTH    = 4,
  parameter int                    QUEUE_ADDR_LEN = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = 32'h0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  if_read_or_not,
  output logic [ADDR_WIDTH-1:0] intru_addr,
  input  logic                  if_load_done,
  input  logic [INST_WIDTH-1:0] mem_ctrl_instru_to_if,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  dec_ready,
  input  logic                  jump_flag,
  input  logic [ADDR_WIDTH-1:0] jump_target
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  push;
  logic                  clear;
  logic                  pop;
  logic                  queue_full;
  logic                  queue_empty;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;

  assign if_read_or_not = req_q;
  assign intru_addr     = addr_q;
  assign if_valid       = !queue_empty;
  assign if_instr       = head_entry.instr;
  assign if_pc          = head_entry.pc;
  assign pop            = if_valid && dec_ready;
  assign push_entry     = '{pc: fetch_pc_q, instr: mem_ctrl_instru_to_if};

  // Fetch FSM: a flush overrides everything; otherwise issue when there is room,
  // then hold the request until memctrl returns the word. Returning to IDLE after
  // each completion gives the gap cycle in which a stale done is ignored.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push       = 1'b0;
    clear      = 1'b0;
    if (rdy_in) begin
      if (jump_flag) begin
        clear      = 1'b1;
        fetch_pc_d = jump_target;
        state_d    = FETCH_IDLE;
        req_d      = 1'b0;
      end else begin
        case (state_q)
          FETCH_IDLE: begin
            if (!queue_full) begin
              req_d   = 1'b1;
              addr_d  = fetch_pc_q;
              state_d = FETCH_WAIT;
            end else begin
              req_d = 1'b0;
            end
          end
          FETCH_WAIT: begin
            if (if_load_done) begin
              push       = 1'b1;
              fetch_pc_d = next_pc(fetch_pc_q);
              req_d      = 1'b0;
              state_d    = FETCH_IDLE;
            end
          end
          default: begin
            state_d = FETCH_IDLE;
            req_d   = 1'b0;
          end
        endcase
      end
    end
  end

  // FSM, PC and memctrl request registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  fetch_queue #(
    .DEPTH    (QUEUE_DEPTH),
    .ADDR_LEN (QUEUE_ADDR_LEN)
  ) u_queue (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .en_in        (rdy_in),
    .clear_in     (clear),
    .push_in      (push),
    .push_data_in (push_entry),
    .pop_in       (pop),
    .full_out     (queue_full),
    .empty_out    (queue_empty),
    .head_out     (head_entry)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a small memctrl model.
module tb_fetch_unit;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        if_read_or_not;
  logic [31:0] intru_addr;
  logic        if_load_done;
  logic [31:0] mem_ctrl_instru_to_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        dec_ready;
  logic        jump_flag;
  logic [31:0] jump_target;

  int pass_count;
  int check_count;

  // memctrl model state
  localparam int MEM_LAT = 6;
  bit model_en;
  bit stale_en;
  bit mem_done_real;
  int mem_cnt;

  fetch_unit #(
    .QUEUE_DEPTH    (4),
    .QUEUE_ADDR_LEN (2),
    .RESET_PC       (32'h0)
  ) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .rdy_in                (rdy_in),
    .if_read_or_not        (if_read_or_not),
    .intru_addr            (intru_addr),
    .if_load_done          (if_load_done),
    .mem_ctrl_instru_to_if (mem_ctrl_instru_to_if),
    .if_valid              (if_valid),
    .if_instr              (if_instr),
    .if_pc                 (if_pc),
    .dec_ready             (dec_ready),
    .jump_flag             (jump_flag),
    .jump_target           (jump_target)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Word memctrl returns for a given address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Count one comparison and report it when it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock and update the memctrl model for the new cycle.
  // Answers MEM_LAT cycles after the request is seen; optionally repeats the
  // completion pulse (stale) in the cycle after it.
  task automatic applyStimulus();
    @(posedge clk_in);
    #1;
    if (!rst_in) begin
      mem_cnt       = 0;
      mem_done_real = 1'b0;
      if_load_done  = 1'b0;
    end else if (mem_done_real) begin
      mem_done_real = 1'b0;
      if_load_done  = stale_en;
      mem_cnt       = 0;
    end else begin
      if_load_done = 1'b0;
      if (model_en && rdy_in && if_read_or_not) begin
        mem_cnt++;
        if (mem_cnt == MEM_LAT) begin
          if_load_done          = 1'b1;
          mem_done_real         = 1'b1;
          mem_ctrl_instru_to_if = memWord(intru_addr);
          mem_cnt               = 0;
        end
      end else if (!if_read_or_not) begin
        mem_cnt = 0;
      end
    end
  endtask

  task automatic waitRequest();
    for (int c = 0; c < 40 && !if_read_or_not; c++) applyStimulus();
    checkOutput("wait_req", {31'd0, if_read_or_not}, 32'd1);
  endtask

  task automatic waitValid();
    for (int c = 0; c < 40 && !if_valid; c++) applyStimulus();
    checkOutput("wait_valid", {31'd0, if_valid}, 32'd1);
  endtask

  // Safety net in case something outside the bounded waits stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_pc;
    int          nreq;
    int          gap;
    bit          prev_req;
    bit          found;

    pass_count            = 0;
    check_count           = 0;
    rst_in                = 1'b0;
    rdy_in                = 1'b1;
    if_load_done          = 1'b0;
    mem_ctrl_instru_to_if = 32'h0;
    dec_ready             = 1'b0;
    jump_flag             = 1'b0;
    jump_target           = 32'h0;
    model_en              = 1'b1;
    stale_en              = 1'b1;
    mem_done_real         = 1'b0;
    mem_cnt               = 0;

    // Reset state
    applyStimulus();
    applyStimulus();
    checkOutput("rst_req",   {31'd0, if_read_or_not}, 32'd0);
    checkOutput("rst_addr",  intru_addr, 32'h0);
    checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_instr", if_instr, 32'h0);
    checkOutput("rst_pc",    if_pc, 32'h0);
    rst_in = 1'b1;

    // Fill with decode stalled; stale done pulses follow every completion
    exp_pc   = 32'h0;
    nreq     = 0;
    gap      = 0;
    prev_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (if_read_or_not && !prev_req) begin
        checkOutput("fill_addr", intru_addr, exp_pc);
        if (nreq > 0) checkOutput("fill_gap", gap, 32'd1);
        exp_pc = exp_pc + 32'd4;
        nreq++;
        gap = 0;
      end
      if (!if_read_or_not) gap++;
      prev_req = if_read_or_not;
      applyStimulus();
    end
    checkOutput("full_nreq",  nreq, 32'd4);
    checkOutput("full_req",   {31'd0, if_read_or_not}, 32'd0);
    checkOutput("full_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("full_pc",    if_pc, 32'h0);
    checkOutput("full_instr", if_instr, memWord(32'h0));

    // Drain in order; exactly four entries
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("drain_pc",    if_pc, 32'(i * 4));
      checkOutput("drain_instr", if_instr, memWord(32'(i * 4)));
      applyStimulus();
    end
    checkOutput("empty_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("empty_pc",    if_pc, 32'h0);
    checkOutput("empty_instr", if_instr, 32'h0);
    waitRequest();
    checkOutput("resume_addr", intru_addr, 32'h10);

    // Asynchronous reset while waiting on memctrl
    rst_in = 1'b0;
    #2;
    checkOutput("async_req",  {31'd0, if_read_or_not}, 32'd0);
    checkOutput("async_addr", intru_addr, 32'h0);
    applyStimulus();
    rst_in   = 1'b1;
    stale_en = 1'b0;
    waitRequest();
    checkOutput("postrst_addr", intru_addr, 32'h0);

    // Flush in the same cycle as the completion for PC 8
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (if_load_done && intru_addr == 32'h8) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("collide_seen", {31'd0, found}, 32'd1);
    jump_flag   = 1'b1;
    jump_target = 32'h100;
    applyStimulus();
    jump_flag = 1'b0;
    checkOutput("flush_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("flush_req",   {31'd0, if_read_or_not}, 32'd0);
    applyStimulus();
    checkOutput("flush_next_req", {31'd0, if_read_or_not}, 32'd1);
    checkOutput("flush_addr",     intru_addr, 32'h100);
    waitValid();
    checkOutput("flush_pc",    if_pc, 32'h100);
    checkOutput("flush_instr", if_instr, memWord(32'h100));

    // Global stall mid-fetch; done and jump are ignored while stalled
    waitRequest();
    checkOutput("stall_addr0", intru_addr, 32'h104);
    model_en = 1'b0;
    rdy_in   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if_load_done          = 1'b1;
      mem_ctrl_instru_to_if = 32'hBAD0_0000;
      jump_flag             = (i == 2);
      jump_target           = 32'h200;
      applyStimulus();
      checkOutput("stall_req",   {31'd0, if_read_or_not}, 32'd1);
      checkOutput("stall_addr",  intru_addr, 32'h104);
      checkOutput("stall_valid", {31'd0, if_valid}, 32'd0);
    end
    jump_flag = 1'b0;
    rdy_in    = 1'b1;
    model_en  = 1'b1;
    waitValid();
    checkOutput("stall_pc",    if_pc, 32'h104);
    checkOutput("stall_instr", if_instr, memWord(32'h104));

    // Back-to-back jumps, the second one exercising PC wrap
    jump_flag   = 1'b1;
    jump_target = 32'h300;
    applyStimulus();
    jump_target = 32'hFFFF_FFFC;
    applyStimulus();
    jump_flag = 1'b0;
    checkOutput("jump_req", {31'd0, if_read_or_not}, 32'd0);
    waitRequest();
    checkOutput("wrap_addr0", intru_addr, 32'hFFFF_FFFC);
    waitValid();
    checkOutput("wrap_pc",    if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_instr", if_instr, memWord(32'hFFFF_FFFC));
    waitRequest();
    checkOutput("wrap_addr1", intru_addr, 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
